// File: rtl/draw_cmd_queue_if.sv
// draw_cmd_queue_if: head-command bus from draw_cmd_queue to draw_obj.
// The queue is the master; draw_obj answers with draw_ready.
interface draw_cmd_queue_if #(
  parameter int SYM_W = 2
);
  logic             cmd_valid;
  logic             draw_ready;
  logic [2:0]       cmd_op;
  logic             cmd_repeat;
  logic [SYM_W-1:0] cmd_sym;
  logic [1:0]       cmd_dir;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_repeat,
    output cmd_sym,
    output cmd_dir,
    input  draw_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_repeat,
    input  cmd_sym,
    input  cmd_dir,
    output draw_ready
  );
endinterface

// File: rtl/draw_cmd_queue.sv
// draw_cmd_queue: classifies game events into prioritised draw commands and
// buffers them in a FIFO. Optional tail coalescing: DRAW_CMD_REPEAT_COALESCE_EN.
module draw_cmd_queue #(
  parameter int NUM_SYMBOLS = 4,
  parameter int DEPTH       = 4,
  parameter int SYM_W       = $clog2(NUM_SYMBOLS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   newGame,
  input  logic                   checkResponse,
  input  logic                   wrong,
  input  logic                   done,
  input  logic [3:0]             dir,
  input  logic [NUM_SYMBOLS-1:0] sym,
  draw_cmd_queue_if.master       cmd,
  output logic                   queue_full,
  output logic [7:0]             drop_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_BOARD = 3'd1;
  localparam logic [2:0] OP_WRONG = 3'd2;
  localparam logic [2:0] OP_CHAR  = 3'd3;
  localparam logic [2:0] OP_TRACK = 3'd4;
  localparam logic [2:0] OP_WIN   = 3'd5;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [2:0]       q_op  [DEPTH];
  logic             q_rep [DEPTH];
  logic [SYM_W-1:0] q_sym [DEPTH];
  logic [1:0]       q_dir [DEPTH];

  logic [PW-1:0] rd;
  logic [PW-1:0] wr;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic          done_q;
  logic [2:0]    last_class;

  logic [2:0]       c_op;
  logic [SYM_W-1:0] c_sym;
  logic [1:0]       c_dir;
  logic             c_rep;
  logic             cand;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic             coalesce;

  always_comb begin
    c_op  = OP_NONE;
    c_sym = '0;
    c_dir = '0;
    priority case (1'b1)
      newGame:               c_op = OP_BOARD;
      checkResponse & wrong: c_op = OP_WRONG;
      |sym: begin
        c_op = OP_CHAR;
        for (int i = NUM_SYMBOLS-1; i >= 0; i--)
          if (sym[i]) c_sym = SYM_W'(i);
      end
      |dir: begin
        c_op = OP_TRACK;
        for (int i = 3; i >= 0; i--)
          if (dir[i]) c_dir = 2'(i);
      end
      done & ~done_q:        c_op = OP_WIN;
      default: ;
    endcase
  end

  assign c_rep = (c_op == OP_CHAR || c_op == OP_TRACK)
              && (c_op == last_class);
  assign cand  = (c_op != OP_NONE) && !newGame;
  assign full  = (count == FULL_CNT);
  assign pop   = cmd.cmd_valid & cmd.draw_ready;

`ifdef DRAW_CMD_REPEAT_COALESCE_EN
  logic [PW-1:0] tail;
  assign tail = wr - 1'b1;
  // A tail that is also the head being popped is gone; push instead.
  assign coalesce = cand
                 && (c_op == OP_CHAR || c_op == OP_TRACK)
                 && (count != '0)
                 && (q_op[tail] == c_op)
                 && !(pop && count == (PW+1)'(1));
`else
  assign coalesce = 1'b0;
`endif

  assign push = cand & ~coalesce & (~full | pop);
  assign drop = cand & ~coalesce & full & ~pop;
  assign count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);

  always_ff @(posedge clk) begin
    if (reset || newGame) begin
      rd         <= '0;
      wr         <= PW'(1);
      count      <= (PW+1)'(1);
      queue_full <= 1'b0;
      q_op[0]    <= OP_BOARD;
      q_rep[0]   <= 1'b0;
      q_sym[0]   <= '0;
      q_dir[0]   <= '0;
      if (reset) begin
        drop_count <= '0;
        done_q     <= 1'b0;
        last_class <= OP_NONE;
      end else begin
        done_q     <= done;
        last_class <= OP_BOARD;
      end
    end else begin
      done_q     <= done;
      count      <= count_nxt;
      queue_full <= (count_nxt == FULL_CNT);
      if (pop) rd <= rd + 1'b1;
      if (push) begin
        q_op[wr]   <= c_op;
        q_rep[wr]  <= c_rep;
        q_sym[wr]  <= c_sym;
        q_dir[wr]  <= c_dir;
        wr         <= wr + 1'b1;
        last_class <= c_op;
      end
`ifdef DRAW_CMD_REPEAT_COALESCE_EN
      if (coalesce) begin
        q_sym[tail] <= c_sym;
        q_dir[tail] <= c_dir;
      end
`endif
      if (drop && drop_count != 8'hff)
        drop_count <= drop_count + 8'd1;
    end
  end

  assign cmd.cmd_valid  = (count != '0);
  assign cmd.cmd_op     = cmd.cmd_valid ? q_op[rd]  : OP_NONE;
  assign cmd.cmd_repeat = cmd.cmd_valid ? q_rep[rd] : 1'b0;
  assign cmd.cmd_sym    = cmd.cmd_valid ? q_sym[rd] : '0;
  assign cmd.cmd_dir    = cmd.cmd_valid ? q_dir[rd] : 2'd0;
endmodule

// File: tb/tb_draw_cmd_queue.sv
// tb_draw_cmd_queue: directed scenarios plus a randomized run checked
// against a queue-based reference model of the command FIFO.
module tb_draw_cmd_queue;
  localparam int NS = 4;
  localparam int D  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          new_game = 1'b0;
  logic          check_response = 1'b0;
  logic          wrong = 1'b0;
  logic          done = 1'b0;
  logic [3:0]    dir = '0;
  logic [NS-1:0] sym = '0;
  logic          queue_full;
  logic [7:0]    drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int op;
    int rep;
    int sy;
    int dr;
  } ent_t;

  ent_t m_q[$];
  int   m_drop;
  int   m_done_q;
  int   m_last;
  bit   model_on = 1'b0;

  always #10 clk = ~clk;

  draw_cmd_queue_if #(.SYM_W(SW)) bus();

  draw_cmd_queue #(
    .NUM_SYMBOLS(NS),
    .DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .newGame(new_game),
    .checkResponse(check_response),
    .wrong(wrong),
    .done(done),
    .dir(dir),
    .sym(sym),
    .cmd(bus.master),
    .queue_full(queue_full),
    .drop_count(drop_count)
  );

  function automatic int lsb(input int v);
    for (int i = 0; i < 32; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  function automatic ent_t board();
    ent_t e;
    e.op = 1; e.rep = 0; e.sy = 0; e.dr = 0;
    return e;
  endfunction

  // Reference: one edge of the queue, from the rules in plain terms.
  task automatic model_edge();
    ent_t e;
    bit   pop_now;
    bit   rise;
    bit   was_full;
    pop_now  = (m_q.size() != 0) && bus.draw_ready;
    rise     = done && (m_done_q == 0);
    was_full = (m_q.size() == D);
    if (reset) begin
      m_q = {board()};
      m_drop = 0; m_done_q = 0; m_last = 0;
      return;
    end
    m_done_q = done;
    if (new_game) begin
      m_q = {board()};
      m_last = 1;
      return;
    end
    e.op = 0; e.rep = 0; e.sy = 0; e.dr = 0;
    if (check_response && wrong) e.op = 2;
    else if (sym != 0) begin e.op = 3; e.sy = lsb(int'(sym)); end
    else if (dir != 0) begin e.op = 4; e.dr = lsb(int'(dir)); end
    else if (rise) e.op = 5;
    if (pop_now) void'(m_q.pop_front());
    if (e.op != 0) begin
      if (!was_full || pop_now) begin
        e.rep = ((e.op == 3 || e.op == 4) && e.op == m_last) ? 1 : 0;
        m_q.push_back(e);
        m_last = e.op;
      end else if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (model_on) model_edge();
    #1;
  endtask

  task automatic clear_in();
    new_game = 0; check_response = 0; wrong = 0;
    sym = '0; dir = '0;
  endtask

  task automatic do_reset();
    clear_in();
    bus.draw_ready = 0;
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'd1) begin
      n_bad++;
      $display("FAIL reset_head: got v=%0d op=%0d want v=1 op=1",
               bus.cmd_valid, bus.cmd_op);
    end
    n_cmp++;
    if (bus.cmd_repeat !== 1'b0 || bus.cmd_sym !== 2'd0 ||
        bus.cmd_dir !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_payload: got r=%0d s=%0d d=%0d want 0 0 0",
               bus.cmd_repeat, bus.cmd_sym, bus.cmd_dir);
    end
    n_cmp++;
    if (queue_full !== 1'b0 || drop_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_flags: got full=%0d drop=%0d want 0 0",
               queue_full, drop_count);
    end
    bus.draw_ready = 1;
    step();
    bus.draw_ready = 0;
    n_cmp++;
    if (bus.cmd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pop: got valid=%0d want 0", bus.cmd_valid);
    end
  endtask

  task automatic test_priority();
    do_reset();
    sym = 4'b0110; dir = 4'b0001;
    step();
    sym = '0; dir = 4'b1000;
    step();
    clear_in();
    bus.draw_ready = 1;
    step();
    n_cmp++;
    if (bus.cmd_op !== 3'd3 || bus.cmd_sym !== 2'd1 ||
        bus.cmd_repeat !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_char: got op=%0d s=%0d r=%0d want 3 1 0",
               bus.cmd_op, bus.cmd_sym, bus.cmd_repeat);
    end
    step();
    n_cmp++;
    if (bus.cmd_op !== 3'd4 || bus.cmd_dir !== 2'd3 ||
        bus.cmd_repeat !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_track: got op=%0d d=%0d r=%0d want 4 3 0",
               bus.cmd_op, bus.cmd_dir, bus.cmd_repeat);
    end
    step();
    bus.draw_ready = 0;
    n_cmp++;
    if (bus.cmd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_empty: got valid=%0d want 0", bus.cmd_valid);
    end
  endtask

  task automatic test_repeat();
    int e_op[4]  = '{3, 3, 2, 3};
    int e_rep[4] = '{0, 1, 0, 0};
    int e_sym[4] = '{0, 3, 0, 2};
    do_reset();
    bus.draw_ready = 1;
    step();
    bus.draw_ready = 0;
    sym = 4'b0001; step();
    sym = 4'b1000; step();
    sym = '0; check_response = 1; wrong = 1; step();
    check_response = 0; wrong = 0; sym = 4'b0100; step();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'(e_op[i]) ||
          bus.cmd_repeat !== 1'(e_rep[i]) ||
          bus.cmd_sym !== 2'(e_sym[i])) begin
        n_bad++;
        $display("FAIL repeat_%0d: got v=%0d op=%0d r=%0d s=%0d want 1 %0d %0d %0d",
                 i, bus.cmd_valid, bus.cmd_op, bus.cmd_repeat, bus.cmd_sym,
                 e_op[i], e_rep[i], e_sym[i]);
      end
      bus.draw_ready = 1;
      step();
      bus.draw_ready = 0;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dir = 4'b0010;
      step();
    end
    clear_in();
    n_cmp++;
    if (queue_full !== 1'b1 || drop_count !== 8'd2) begin
      n_bad++;
      $display("FAIL ovf_full: got full=%0d drop=%0d want 1 2",
               queue_full, drop_count);
    end
    dir = 4'b0010;
    bus.draw_ready = 1;
    step();
    clear_in();
    bus.draw_ready = 0;
    n_cmp++;
    if (queue_full !== 1'b1 || drop_count !== 8'd2) begin
      n_bad++;
      $display("FAIL ovf_pushpop: got full=%0d drop=%0d want 1 2",
               queue_full, drop_count);
    end
    n_cmp++;
    if (bus.cmd_op !== 3'd4 || bus.cmd_dir !== 2'd1 ||
        bus.cmd_repeat !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_head: got op=%0d d=%0d r=%0d want 4 1 0",
               bus.cmd_op, bus.cmd_dir, bus.cmd_repeat);
    end
  endtask

  task automatic test_win_once();
    int wins = 0;
    do_reset();
    bus.draw_ready = 1;
    done = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.cmd_valid && bus.cmd_op == 3'd5) wins++;
    end
    n_cmp++;
    if (wins != 1) begin
      n_bad++;
      $display("FAIL win_once: got %0d wins want 1", wins);
    end
    done = 0;
    step();
    if (bus.cmd_valid && bus.cmd_op == 3'd5) wins++;
    done = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.cmd_valid && bus.cmd_op == 3'd5) wins++;
    end
    done = 0;
    bus.draw_ready = 0;
    n_cmp++;
    if (wins != 2) begin
      n_bad++;
      $display("FAIL win_again: got %0d wins want 2", wins);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sym = 4'(1 << (i % 4));
      step();
    end
    clear_in();
    new_game = 1;
    bus.draw_ready = 1;
    step();
    new_game = 0;
    bus.draw_ready = 0;
    n_cmp++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'd1 ||
        queue_full !== 1'b0 || drop_count !== 8'd2) begin
      n_bad++;
      $display("FAIL flush: got v=%0d op=%0d full=%0d drop=%0d want 1 1 0 2",
               bus.cmd_valid, bus.cmd_op, queue_full, drop_count);
    end
    bus.draw_ready = 1;
    step();
    bus.draw_ready = 0;
    n_cmp++;
    if (bus.cmd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_count: got valid=%0d want 0", bus.cmd_valid);
    end
  endtask

  task automatic test_random();
    ent_t h;
    model_on = 1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(99) == 0);
      new_game       = ($urandom_range(40) == 0);
      check_response = ($urandom_range(5) == 0);
      wrong          = $urandom_range(1);
      sym = ($urandom_range(3) == 0) ? NS'($urandom) : '0;
      dir = ($urandom_range(2) == 0) ? 4'($urandom) : '0;
      if ($urandom_range(7) == 0) done = ~done;
      bus.draw_ready = (i < 300) ? ($urandom_range(3) == 0)
                                 : ($urandom_range(3) != 0);
      step();
      n_cmp++;
      if (bus.cmd_valid !== (m_q.size() != 0)) begin
        n_bad++;
        $display("FAIL rnd_valid@%0d: got %0d want %0d",
                 i, bus.cmd_valid, m_q.size() != 0);
      end
      n_cmp++;
      if (queue_full !== (m_q.size() == D) || drop_count !== 8'(m_drop)) begin
        n_bad++;
        $display("FAIL rnd_flags@%0d: got full=%0d drop=%0d want %0d %0d",
                 i, queue_full, drop_count, m_q.size() == D, m_drop);
      end
      if (m_q.size() != 0) begin
        h = m_q[0];
        n_cmp++;
        if (bus.cmd_op !== 3'(h.op) || bus.cmd_repeat !== 1'(h.rep) ||
            bus.cmd_sym !== 2'(h.sy) || bus.cmd_dir !== 2'(h.dr)) begin
          n_bad++;
          $display("FAIL rnd_head@%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                   i, bus.cmd_op, bus.cmd_repeat, bus.cmd_sym, bus.cmd_dir,
                   h.op, h.rep, h.sy, h.dr);
        end
      end
    end
    clear_in();
    reset = 0;
    done = 0;
    bus.draw_ready = 0;
    model_on = 0;
  endtask

  initial begin
    bus.draw_ready = 0;
    test_reset();
    test_priority();
    test_repeat();
    test_overflow();
    test_win_once();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
